// File: rtl/delay_pipe.sv
// Fixed-latency stallable delay line carrying a data word and its go qualifier
// through DEPTH register stages, with a counter-based in-flight occupancy.
module delay_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic                         flush,
  input  logic                         go,
  input  logic [WIDTH-1:0]             in,
  output logic [WIDTH-1:0]             out,
  output logic                         out_go,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;

  // Next-state: shift on enable, then flush clears every valid including the incoming one
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    occ_d   = occ_q;
    if (en) begin
      data_d[0]  = in;
      valid_d[0] = go;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        data_d[i]  = data_q[i-1];
        valid_d[i] = valid_q[i-1];
      end
      occ_d = occ_q + OCC_W'(go) - OCC_W'(valid_q[DEPTH-1]);
    end
    if (flush) begin
      valid_d = '0;
      occ_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
      valid_q <= '0;
      occ_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      occ_q   <= occ_d;
    end
  end

  assign out       = data_q[DEPTH-1];
  assign out_go    = valid_q[DEPTH-1];
  assign occupancy = occ_q;

endmodule

// File: tb/tb_delay_pipe.sv
// Self-checking bench for delay_pipe: DEPTH=3 and DEPTH=1 instances share one
// stimulus stream and are compared against a history-queue model every cycle.
module tb_delay_pipe;

  logic       clk;
  logic       reset;
  logic       en;
  logic       flush;
  logic       go;
  logic [7:0] din;

  logic [7:0] out3;
  logic       go3;
  logic [1:0] occ3;
  logic [7:0] out1;
  logic       go1;
  logic [0:0] occ1;

  int checks   = 0;
  int failures = 0;

  delay_pipe #(.WIDTH(8), .DEPTH(3)) u_d3 (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .go(go), .in(din),
    .out(out3), .out_go(go3), .occupancy(occ3)
  );

  delay_pipe #(.WIDTH(8), .DEPTH(1)) u_d1 (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .go(go), .in(din),
    .out(out1), .out_go(go1), .occupancy(occ1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: history of words accepted on enabled edges, newest first.
  // A DEPTH=D pipe outputs entry D-1; occupancy is the valid count among the first D.
  typedef struct packed {
    logic       v;
    logic [7:0] d;
  } ent_t;

  ent_t hist[$];
  bit   mvalid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      hist.delete();
      repeat (3) hist.push_back('0);
      mvalid = 1'b1;
    end else if (mvalid) begin
      if (flush) begin
        foreach (hist[i]) hist[i].v = 1'b0;
      end
      if (en) begin
        hist.push_front({go && !flush, din});
        void'(hist.pop_back());
      end
    end
  end

  function automatic int model_occ(input int dep);
    int n = 0;
    for (int i = 0; i < dep; i++) n += int'(hist[i].v);
    return n;
  endfunction

  always @(negedge clk) begin
    if (mvalid) begin
      chk("model_out_d3", 32'(out3), 32'(hist[2].d));
      chk("model_go_d3",  32'(go3),  32'(hist[2].v));
      chk("model_occ_d3", 32'(occ3), 32'(model_occ(3)));
      chk("model_out_d1", 32'(out1), 32'(hist[0].d));
      chk("model_go_d1",  32'(go1),  32'(hist[0].v));
      chk("model_occ_d1", 32'(occ1), 32'(model_occ(1)));
    end
  end

  // Drive at negedge, let one rising edge pass, return at the next negedge
  task automatic cyc(input logic e, input logic f, input logic g, input logic [7:0] d);
    en = e; flush = f; go = g; din = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    en = 1'b1; flush = 1'b0; go = 1'b0; din = 8'h00; reset = 1'b1;
    @(negedge clk);

    // Reset held two cycles with go/in active
    cyc(1, 0, 1, 8'hFF);
    cyc(1, 0, 1, 8'hFF);
    chk("rst_out3", 32'(out3), 32'h0);
    chk("rst_go3",  32'(go3),  32'h0);
    chk("rst_occ3", 32'(occ3), 32'h0);
    reset = 1'b0;
    cyc(1, 0, 0, 8'h00);
    chk("rst_hold_go3",  32'(go3),  32'h0);
    chk("rst_hold_occ1", 32'(occ1), 32'h0);

    // Latency of a single word
    cyc(1, 0, 1, 8'hA5);
    chk("lat_c1_occ", 32'(occ3), 32'd1);
    chk("lat_c1_go",  32'(go3),  32'h0);
    cyc(1, 0, 0, 8'h00);
    chk("lat_c2_occ", 32'(occ3), 32'd1);
    chk("lat_c2_go",  32'(go3),  32'h0);
    cyc(1, 0, 0, 8'h00);
    chk("lat_c3_go",  32'(go3),  32'h1);
    chk("lat_c3_out", 32'(out3), 32'hA5);
    chk("lat_c3_occ", 32'(occ3), 32'd1);
    cyc(1, 0, 0, 8'h00);
    chk("lat_c4_go",  32'(go3),  32'h0);
    chk("lat_c4_occ", 32'(occ3), 32'd0);

    // Back-to-back words
    cyc(1, 0, 1, 8'h01);
    cyc(1, 0, 1, 8'h02);
    cyc(1, 0, 1, 8'h03);
    chk("b2b_peak_occ", 32'(occ3), 32'd3);
    chk("b2b_out1",     32'(out3), 32'h01);
    chk("b2b_go1",      32'(go3),  32'h1);
    cyc(1, 0, 0, 8'h00);
    chk("b2b_out2", 32'(out3), 32'h02);
    chk("b2b_occ2", 32'(occ3), 32'd2);
    cyc(1, 0, 0, 8'h00);
    chk("b2b_out3", 32'(out3), 32'h03);
    chk("b2b_occ3", 32'(occ3), 32'd1);
    cyc(1, 0, 0, 8'h00);
    chk("b2b_drain_occ", 32'(occ3), 32'd0);
    chk("b2b_drain_go",  32'(go3),  32'h0);

    // Stall: word held two cycles, words offered during the stall are dropped
    cyc(1, 0, 1, 8'h11);
    cyc(0, 0, 1, 8'h99);
    cyc(0, 0, 1, 8'h99);
    chk("stall_occ", 32'(occ3), 32'd1);
    chk("stall_go",  32'(go3),  32'h0);
    chk("stall_go1", 32'(go1),  32'h1);
    chk("stall_out1", 32'(out1), 32'h11);
    cyc(1, 0, 0, 8'h00);
    chk("stall_c4_go", 32'(go3), 32'h0);
    cyc(1, 0, 0, 8'h00);
    chk("stall_c5_out", 32'(out3), 32'h11);
    chk("stall_c5_go",  32'(go3),  32'h1);
    repeat (4) begin
      cyc(1, 0, 0, 8'h00);
      chk("stall_no99_go", 32'(go3), 32'h0);
    end

    // Flush colliding with an incoming go
    cyc(1, 0, 1, 8'h21);
    cyc(1, 0, 1, 8'h22);
    chk("fl_pre_occ", 32'(occ3), 32'd2);
    chk("d1_out",     32'(out1), 32'h22);
    chk("d1_go",      32'(go1),  32'h1);
    cyc(1, 1, 1, 8'h77);
    chk("fl_occ",    32'(occ3), 32'd0);
    chk("fl_go",     32'(go3),  32'h0);
    chk("fl_go1",    32'(go1),  32'h0);
    repeat (4) begin
      cyc(1, 0, 0, 8'h00);
      chk("fl_after_go", 32'(go3), 32'h0);
    end

    // Reset mid-flight discards three words
    cyc(1, 0, 1, 8'h31);
    cyc(1, 0, 1, 8'h32);
    cyc(1, 0, 1, 8'h33);
    chk("rmid_pre_occ", 32'(occ3), 32'd3);
    reset = 1'b1;
    cyc(1, 0, 1, 8'h44);
    reset = 1'b0;
    chk("rmid_occ", 32'(occ3), 32'd0);
    chk("rmid_out", 32'(out3), 32'h0);
    repeat (4) begin
      cyc(1, 0, 0, 8'h00);
      chk("rmid_after_go", 32'(go3), 32'h0);
    end

    // Single-stage pipe
    cyc(1, 0, 1, 8'h5A);
    chk("d1_5a_out", 32'(out1), 32'h5A);
    chk("d1_5a_go",  32'(go1),  32'h1);
    chk("d1_5a_occ", 32'(occ1), 32'd1);
    cyc(1, 0, 0, 8'h00);
    chk("d1_5a_exit_go",  32'(go1),  32'h0);
    chk("d1_5a_exit_occ", 32'(occ1), 32'd0);

    // Mixed traffic checked by the model only
    for (int k = 0; k < 300; k++) begin
      reset = ($urandom_range(0, 63) == 0);
      cyc(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 15) == 0),
          logic'($urandom_range(0, 1)), 8'($urandom));
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/delay_pipe.md
# delay_pipe

Fixed-latency, stallable delay line that carries a data word and its `_go` qualifier through `DEPTH` register stages. It sits directly upstream of `Latch` and `Mux` primitives: it realigns a value produced at one event time to the cycle where a downstream latch's `write_en` or a mux's operands are sampled. An in-flight occupancy count is provided so schedulers and assertions can check the pipeline is drained.

## Interface
- `WIDTH`, 32, data word width in bits; ≥1.
- `DEPTH`, 2, number of register stages (latency in enabled cycles); ≥1.
- `clk`  input  1  clock, rising edge.
- `reset`  input  1  reset, synchronous, active-high.
- `en`  input  1  advance enable; 0 freezes all stages.
- `flush`  input  1  synchronous clear of all valid bits.
- `go`  input  1  valid qualifier for `in` this cycle.
- `in`  input  WIDTH  data entering stage 0.
- `out`  output  WIDTH  data of stage DEPTH-1.
- `out_go`  output  1  valid bit of stage DEPTH-1.
- `occupancy`  output  $clog2(DEPTH+1)  number of stages currently holding a valid word.

## Operation
- Storage: `DEPTH` data registers d[0..DEPTH-1] and `DEPTH` valid bits v[0..DEPTH-1]; `out`=d[DEPTH-1], `out_go`=v[DEPTH-1], both direct register outputs (no combinational path from inputs).
- Reset (highest priority): all d[i] ← 0, all v[i] ← 0, occupancy ← 0. `out`=0, `out_go`=0, `occupancy`=0 in the cycle after reset is sampled high. Reset mid-operation discards all in-flight words.
- Flush (next priority): all v[i] ← 0 and occupancy ← 0, including the incoming `go` of that cycle. Data registers shift if `en`=1, else hold; data contents after flush are don't-care for consumers but must be deterministic.
- Advance (`en`=1, no flush): d[0] ← in, v[0] ← go; d[i] ← d[i-1], v[i] ← v[i-1] for i≥1. Data shifts regardless of valid bits.
- Stall (`en`=0, no flush): all d, v, occupancy hold. `go`/`in` presented during a stall are dropped.
- Occupancy: maintained as a counter, not a popcount. On advance: occupancy ← occupancy + go − v[DEPTH-1]. Simultaneous go and valid exit leaves it unchanged. Must always equal popcount(v); never exceeds DEPTH, never underflows.
- DEPTH=1: single stage; all rules above hold with d[0]/v[0] as the output stage.

## Timing
- Latency: exactly DEPTH enabled cycles. With `en` held high, (go,in) sampled at edge t appear on (`out_go`,`out`) after edge t+DEPTH−1, i.e. visible in cycle t+DEPTH.
- Stalls add one cycle of latency per `en`=0 cycle while the word is in flight; no bubbles are inserted or removed.
- Throughput: one word per enabled cycle; back-to-back `go` fully supported.
- `occupancy` updates on the same edge as the valid bits; no extra cycle of lag.
- Flush and reset take effect on the sampling edge; outputs show cleared valids the following cycle.

## Test plan
- Reset: assert reset 2 cycles with go=1, in=0xFF -> `out`=0, `out_go`=0, `occupancy`=0 after release; holds until first go.
- Latency, DEPTH=3, WIDTH=8, en=1: go=1, in=0xA5 at cycle 0, go=0 after -> `out_go`=1, `out`=0xA5 only in cycle 3; `occupancy` 1,1,1 in cycles 1–3, then 0.
- Back-to-back: go=1, in=0x01,0x02,0x03 in cycles 0–2 -> `out` 0x01,0x02,0x03 in cycles 3–5 with `out_go`=1; occupancy peaks at 3, drops to 0 in cycle 6.
- Stall: send 0x11 at cycle 0, en=0 in cycles 1–2 -> 0x11 appears in cycle 5 with `out_go`=1; `go`=1, in=0x99 during the stall never emerges.
- Flush collision: occupancy=2, then flush=1 together with go=1, in=0x77 -> next cycle occupancy=0, `out_go` stays 0 for the following 4 cycles; 0x77 never marked valid.
- Reset mid-flight plus DEPTH=1 variant: three words in flight, reset for 1 cycle -> no `out_go` pulse afterwards; with DEPTH=1, go=1, in=0x5A -> `out`=0x5A, `out_go`=1 in the next cycle.
